// File: rtl/idex_pkg.sv
// Shared definitions for the ID/EX pipeline register: state codes and the
// default field layout of the control and data bundles.
package idex_pkg;

  // Occupancy states. FULL is only reachable when the skid entry exists.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_MAIN  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // Default control bundle bit positions (CTRL_W = 10).
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_ALUSRC    = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_ALUOP_LSB = 3;  // ALUOp[1:0] at bits 4:3
  localparam int CTRL_MEMTOREG  = 5;
  localparam int CTRL_MEMREAD   = 6;
  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_JUMP      = 8;
  localparam int CTRL_REGDST    = 9;

  // Default data bundle field offsets (DATA_W = 175), LSB first.
  localparam int DATA_RD_LSB    = 0;    // rd  [4:0]
  localparam int DATA_RT_LSB    = 5;    // rt  [4:0]
  localparam int DATA_RS_LSB    = 10;   // rs  [4:0]
  localparam int DATA_IMM_LSB   = 15;   // imm [31:0]
  localparam int DATA_RD2_LSB   = 47;   // rd2 [31:0]
  localparam int DATA_RD1_LSB   = 79;   // rd1 [31:0]
  localparam int DATA_PC_LSB    = 111;  // pc  [31:0]
  localparam int DATA_JADDR_LSB = 143;  // jumpaddr [31:0]
  localparam int DATA_W_DEFAULT = 175;

endpackage

// File: rtl/idex_pipe_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; used for stall accounting.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)                q <= '0;
    else if (clr)              q <= '0;
    else if (inc && (q != '1)) q <= q + 1'b1;
  end

endmodule

// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), synchronous flush and a stall-cycle counter.
module idex_pipe_stage
  import idex_pkg::*;
#(
  parameter int CTRL_W              = 10,
  parameter int DATA_W              = 175,
  parameter bit SKID                = 1'b1,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  logic [1:0]        state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_ready_q;
  logic              in_fire, out_fire;
  logic              ld_main_in, ld_skid_in, ld_main_skid;

  assign out_valid = (state != ST_EMPTY);
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
  assign out_data  = main_data;

  // With the skid entry, ready comes straight from a flop so the upstream
  // timing path is cut; without it, ready must look at out_ready directly.
  assign in_ready = SKID ? in_ready_q : (!out_valid || out_ready);

  assign in_fire  = in_valid  && in_ready;
  assign out_fire = out_valid && out_ready;

  // Entry load selects. In MAIN a new bundle replaces main only when the
  // current one leaves this cycle; otherwise it parks in the skid entry.
  // Without SKID, in_fire in MAIN implies out_ready, so the skid never loads.
  assign ld_main_in   = in_fire && ((state == ST_EMPTY) ||
                                    ((state == ST_MAIN) && out_fire));
  assign ld_skid_in   = in_fire && (state == ST_MAIN) && !out_ready;
  assign ld_main_skid = (state == ST_FULL) && out_fire;

  // Occupancy next-state (flush is applied in the register block).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_fire) state_nxt = ST_MAIN;
      ST_MAIN: begin
        if (in_fire && out_fire) state_nxt = ST_MAIN;
        else if (in_fire)        state_nxt = ST_FULL;
        else if (out_fire)       state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (out_fire) state_nxt = ST_MAIN;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // State, registered ready and control entries; flush empties the stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
      if (ld_main_in)        main_ctrl <= in_ctrl;
      else if (ld_main_skid) main_ctrl <= skid_ctrl;
      if (ld_skid_in)        skid_ctrl <= in_ctrl;
    end
  end

  // Data entries; on flush they keep their contents unless clearing is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      if (CLEAR_DATA_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (ld_main_in)        main_data <= in_data;
      else if (ld_main_skid) main_data <= skid_data;
      if (ld_skid_in)        skid_data <= in_data;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (out_valid && !out_ready),
    .q     (stall_cnt)
  );

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Bench for idex_pipe_stage: a default build (SKID=1, CNT_W=16) and a
// SKID=0 / CNT_W=4 / CLEAR_DATA_ON_FLUSH=1 build share one stimulus stream
// and are each compared every cycle against a small FIFO-occupancy model.
module tb_idex_pipe_stage;

  localparam int CW = 10;
  localparam int DW = 175;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          ir [2];
  logic          ov [2];
  logic [CW-1:0] oc [2];
  logic [DW-1:0] od [2];
  logic [15:0]   sc0;
  logic [3:0]    sc1;

  always #5 clk = ~clk;

  idex_pipe_stage u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
    .stall_cnt(sc0), .cnt_clr(cnt_clr)
  );

  idex_pipe_stage #(.SKID(1'b0), .CNT_W(4), .CLEAR_DATA_ON_FLUSH(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
    .stall_cnt(sc1), .cnt_clr(cnt_clr)
  );

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  ent_t          fifo [2][2];
  int            n    [2];
  logic [DW-1:0] last_d [2];  // value the data register holds while empty
  int            cnt  [2];
  bit            armed = 1'b0;
  int            cyc_n = 0;
  int            checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] x = '0;
    for (int k = 0; k < 6; k++) x = {x[159:0], 32'($urandom())};
    return x[DW-1:0];
  endfunction

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic cyc(input logic r, input logic f, input logic iv, input logic [CW-1:0] c,
                     input logic [DW-1:0] d, input logic ordy, input logic clr);
    @(negedge clk);
    rst_n = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d;
    out_ready = ordy; cnt_clr = clr;
    #1;
    for (int i = 0; i < 2; i++) begin
      logic          e_rdy, e_v;
      logic [CW-1:0] e_c;
      logic [DW-1:0] e_d;
      int            cmax;
      string         nm;
      nm    = (i == 0) ? "skid" : "noskid";
      cmax  = (i == 0) ? 65535 : 15;
      e_v   = (n[i] != 0);
      e_rdy = (i == 0) ? (n[i] < 2) : (n[i] == 0 || ordy);
      e_c   = e_v ? fifo[i][0].c : '0;
      e_d   = e_v ? fifo[i][0].d : last_d[i];
      if (armed) begin
        chk($sformatf("%s.out_valid@%0d", nm, cyc_n), 256'(ov[i]), 256'(e_v));
        chk($sformatf("%s.out_ctrl@%0d", nm, cyc_n), 256'(oc[i]), 256'(e_c));
        chk($sformatf("%s.out_data@%0d", nm, cyc_n), 256'(od[i]), 256'(e_d));
        chk($sformatf("%s.in_ready@%0d", nm, cyc_n), 256'(ir[i]), 256'(e_rdy));
        chk($sformatf("%s.stall_cnt@%0d", nm, cyc_n),
            (i == 0) ? 256'(sc0) : 256'(sc1), 256'(cnt[i]));
      end
      if (!r) begin
        n[i] = 0; last_d[i] = '0; cnt[i] = 0;
      end else begin
        if (clr)                    cnt[i] = 0;
        else if (e_v && !ordy && cnt[i] < cmax) cnt[i]++;
        if (f) begin
          n[i] = 0;
          if (i == 1) last_d[i] = '0;
        end else begin
          if (e_v && ordy) begin
            fifo[i][0] = fifo[i][1];
            n[i]--;
          end
          if (iv && e_rdy) begin
            fifo[i][n[i]] = '{c: c, d: d};
            n[i]++;
          end
          if (n[i] != 0) last_d[i] = fifo[i][0].d;
        end
      end
    end
    if (!r) armed = 1'b1;
    cyc_n++;
  endtask

  initial begin
    logic [DW-1:0] da, db, dc, dd;
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; cnt[i] = 0; last_d[i] = '0;
    end
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cnt_clr = 1'b0; in_ctrl = '0; in_data = '0;

    // Reset held with a bundle presented upstream.
    cyc(0, 0, 1, 10'h3FF, rnd_data(), 1, 0);
    cyc(0, 0, 1, 10'h3FF, rnd_data(), 1, 0);

    // Streaming with EX always ready.
    for (int k = 1; k <= 5; k++) cyc(1, 0, 1, 10'h201, DW'(k), 1, 0);
    cyc(1, 0, 0, '0, '0, 1, 0);

    // Backpressure: A, B, C with EX stalled, then release.
    da = rnd_data(); db = rnd_data(); dc = rnd_data();
    cyc(1, 0, 1, 10'h0A1, da, 0, 0);
    cyc(1, 0, 1, 10'h0B2, db, 0, 0);
    cyc(1, 0, 1, 10'h0C3, dc, 0, 0);
    cyc(1, 0, 1, 10'h0C3, dc, 0, 0);
    cyc(1, 0, 1, 10'h0C3, dc, 0, 0);
    cyc(1, 0, 1, 10'h0C3, dc, 1, 0);
    cyc(1, 0, 1, 10'h0C3, dc, 1, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, '0, '0, 1, 0);

    // Flush while full, with a new bundle D offered in the flush cycle.
    dd = rnd_data();
    cyc(1, 0, 1, 10'h111, rnd_data(), 0, 1);
    cyc(1, 0, 1, 10'h122, rnd_data(), 0, 0);
    cyc(1, 1, 1, 10'h1DD, dd, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 0);
    cyc(1, 0, 0, '0, '0, 1, 0);

    // Counter saturation on the 4-bit build, then clear.
    cyc(1, 0, 1, 10'h155, rnd_data(), 0, 0);
    for (int k = 0; k < 20; k++) cyc(1, 0, 0, '0, '0, 0, 0);
    cyc(1, 0, 0, '0, '0, 0, 1);
    cyc(1, 0, 0, '0, '0, 0, 0);

    // Stall with one entry held on the combinational-ready build, then release.
    cyc(1, 1, 0, '0, '0, 0, 0);
    cyc(1, 0, 1, 10'h066, rnd_data(), 0, 0);
    cyc(1, 0, 1, 10'h077, rnd_data(), 0, 0);
    cyc(1, 0, 1, 10'h077, rnd_data(), 1, 0);
    cyc(1, 0, 0, '0, '0, 1, 0);

    // Randomised traffic including occasional reset, flush and clear.
    for (int k = 0; k < 600; k++) begin
      logic r, f, iv, ordy, clr;
      r    = ($urandom_range(0, 99) != 0);
      f    = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 9) < 6);
      clr  = ($urandom_range(0, 31) == 0);
      cyc(r, f, iv, CW'($urandom()), rnd_data(), ordy, clr);
    end
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, '0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
